// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module  : wb_arb_pkg
// Brief   : Shared widths and types for the register-file write-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  typedef struct packed {
    logic    valid;
    logic    killed;
    wb_req_t req;
  } wb_q_entry_t;

  function automatic logic entry_live(input wb_q_entry_t e);
    return e.valid && !e.killed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_req_fifo.sv
// ============================================================================
// Module  : wb_req_fifo
// Brief   : Circular queue of secondary write results with per-entry kill bits
//           and a parallel destination-register compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import wb_arb_pkg::*;

module wb_req_fifo #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_req_t           push_req_i,
  input  logic              push_killed_i,
  input  logic              pop_i,
  input  logic [DEPTH-1:0]  kill_i,
  input  logic [REG_AW-1:0] cmp_rd_i,
  output logic [DEPTH-1:0]  match_o,
  output wb_q_entry_t       head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              pending_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  wb_q_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] w_live;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign match_o[i] = mem_q[i].valid && (mem_q[i].req.rd == cmp_rd_i);
    assign w_live[i]  = entry_live(mem_q[i]);
  end

  assign pending_o = |w_live;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i[i]) begin
          mem_q[i].killed <= 1'b1;
        end
      end
      if (pop_i && !empty_o) begin
        mem_q[rd_ptr_q[AW-1:0]].valid <= 1'b0;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= '{valid: 1'b1, killed: push_killed_i, req: push_req_i};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module  : wb_port_arbiter
// Brief   : Shares the register-file write port between writeback and a queued
//           secondary result source. Optional starvation guard is enabled by
//           defining WB_ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import wb_arb_pkg::*;

module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_we,
  input  logic [REG_AW-1:0] p_rd,
  input  logic [XLEN-1:0]   p_wd,
  input  logic              s_valid,
  input  logic [REG_AW-1:0] s_rd,
  input  logic [XLEN-1:0]   s_wd,
  output logic              s_ready,
  output logic              stall,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  output logic              s_pending
);

  typedef logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt_t;

  logic             w_full;
  logic             w_empty;
  logic             w_pending;
  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_kill;
  wb_q_entry_t      w_head;
  logic             w_p_req;
  logic             w_head_live;
  logic             w_trip;
  logic             w_pop;
  logic             w_p_grant;
  logic             w_push;
  logic             w_push_killed;

  assign w_p_req     = p_we && (p_rd != '0);
  assign w_head_live = !w_empty && w_head.valid && !w_head.killed;

  always_comb begin
    we3       = 1'b0;
    a3        = '0;
    wd3       = '0;
    stall     = 1'b0;
    w_pop     = 1'b0;
    w_p_grant = 1'b0;
    if (!reset) begin
      if (w_trip) begin
        we3   = 1'b1;
        a3    = w_head.req.rd;
        wd3   = w_head.req.wd;
        stall = 1'b1;
        w_pop = 1'b1;
      end else if (w_p_req) begin
        we3       = 1'b1;
        a3        = p_rd;
        wd3       = p_wd;
        w_p_grant = 1'b1;
      end else if (w_head_live) begin
        we3   = 1'b1;
        a3    = w_head.req.rd;
        wd3   = w_head.req.wd;
        w_pop = 1'b1;
      end else if (!w_empty) begin
        w_pop = 1'b1;
      end
    end
  end

  // Queued results are older than WB, so a P write to the same rd retires them.
  assign w_kill        = w_match & {DEPTH{w_p_grant}};
  assign w_push_killed = w_p_grant && (s_rd == p_rd);
  assign s_ready       = !w_full && !reset;
  assign w_push        = s_valid && s_ready && (s_rd != '0);
  assign s_pending     = w_pending && !reset;

  wb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (w_push),
    .push_req_i    ('{rd: s_rd, wd: s_wd}),
    .push_killed_i (w_push_killed),
    .pop_i         (w_pop),
    .kill_i        (w_kill),
    .cmp_rd_i      (p_rd),
    .match_o       (w_match),
    .head_o        (w_head),
    .full_o        (w_full),
    .empty_o       (w_empty),
    .pending_o     (w_pending)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam starve_cnt_t C_STARVE_MAX = starve_cnt_t'(STARVE_MAX);

  starve_cnt_t starve_q;
  starve_cnt_t starve_d;

  assign w_trip = w_head_live && (starve_q == C_STARVE_MAX) && w_p_req;

  // A live head that is not beaten by P is being granted, so anything else clears.
  always_comb begin
    starve_d = '0;
    if (w_head_live && w_p_grant) begin
      starve_d = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign w_trip = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module  : tb_wb_port_arbiter
// Brief   : Directed self-checking bench for wb_port_arbiter (DEPTH=2,
//           STARVE_MAX=4); guard expectations follow WB_ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_rd;
  logic [31:0] p_wd;
  logic        s_valid;
  logic [4:0]  s_rd;
  logic [31:0] s_wd;
  logic        s_ready;
  logic        stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        s_pending;

  int nvec;
  int nerr;

  logic [31:0] rf [32];
  logic [31:0] wrote;

  wb_port_arbiter #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p_we      (p_we),
    .p_rd      (p_rd),
    .p_wd      (p_wd),
    .s_valid   (s_valid),
    .s_rd      (s_rd),
    .s_wd      (s_wd),
    .s_ready   (s_ready),
    .stall     (stall),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .s_pending (s_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file fed by the write port.
  always @(posedge clk) begin
    if (we3) begin
      rf[a3]    <= wd3;
      wrote[a3] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic sv, input logic [4:0] srd, input logic [31:0] swd);
    p_we    = pwe;
    p_rd    = prd;
    p_wd    = pwd;
    s_valid = sv;
    s_rd    = srd;
    s_wd    = swd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we3"}, {31'd0, we3}, {31'd0, we});
    if (we) begin
      chk({tag, "_a3"}, {27'd0, a3}, {27'd0, a});
      chk({tag, "_wd3"}, wd3, d);
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    wrote = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset: outputs forced low even with requests present
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h4);
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_a3", {27'd0, a3}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_s_pending", {31'd0, s_pending}, 32'd0);
    tick;
    tick;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_pending", {31'd0, s_pending}, 32'd0);

    // Idle P, single secondary push drains next cycle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5A5A5A5);
    chk("t1_ready", {31'd0, s_ready}, 32'd1);
    chk_wr("t1_c0", 1'b0, 5'd0, 32'h0);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t1_pending", {31'd0, s_pending}, 32'd1);
    chk_wr("t1_c1", 1'b1, 5'd5, 32'hA5A5A5A5);
    tick;
    chk("t1_pending_fall", {31'd0, s_pending}, 32'd0);
    chk_wr("t1_c2", 1'b0, 5'd0, 32'h0);
    chk("t1_rf5", rf[5], 32'hA5A5A5A5);

    // P busy on x7, three pushes, queue fills after two
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd1, 32'h101);
    chk("t2_ready0", {31'd0, s_ready}, 32'd1);
    chk_wr("t2_c0", 1'b1, 5'd7, 32'h77);
    tick;
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd2, 32'h102);
    chk("t2_ready1", {31'd0, s_ready}, 32'd1);
    chk_wr("t2_c1", 1'b1, 5'd7, 32'h77);
    tick;
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h103);
    chk("t2_ready_full", {31'd0, s_ready}, 32'd0);
    chk_wr("t2_c2", 1'b1, 5'd7, 32'h77);
    tick;
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    chk_wr("t2_c3", 1'b1, 5'd7, 32'h77);
    chk("t2_stall", {31'd0, stall}, 32'd0);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk_wr("t2_drain_x1", 1'b1, 5'd1, 32'h101);
    chk("t2_ready_popfull", {31'd0, s_ready}, 32'd0);
    tick;
    chk_wr("t2_drain_x2", 1'b1, 5'd2, 32'h102);
    chk("t2_ready_back", {31'd0, s_ready}, 32'd1);
    tick;
    chk_wr("t2_idle", 1'b0, 5'd0, 32'h0);
    chk("t2_pending", {31'd0, s_pending}, 32'd0);
    chk("t2_x3_dropped", {31'd0, wrote[3]}, 32'd0);

    // Queued x9 killed by a younger P write
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h11);
    chk_wr("t3_c0", 1'b1, 5'd8, 32'h88);
    tick;
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
    chk("t3_pending_live", {31'd0, s_pending}, 32'd1);
    chk_wr("t3_c1", 1'b1, 5'd9, 32'h22);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t3_pending_killed", {31'd0, s_pending}, 32'd0);
    chk_wr("t3_killed_pop", 1'b0, 5'd0, 32'h0);
    tick;
    chk_wr("t3_after", 1'b0, 5'd0, 32'h0);
    chk("t3_rf9", rf[9], 32'h22);

    // Same-cycle push to P's rd arrives killed
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 32'hBB);
    chk_wr("t3b_c0", 1'b1, 5'd10, 32'hAA);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t3b_pending", {31'd0, s_pending}, 32'd0);
    chk_wr("t3b_c1", 1'b0, 5'd0, 32'h0);
    tick;
    chk("t3b_rf10", rf[10], 32'hAA);

    // Starvation: continuous P to x4 with x6 queued behind it
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd6, 32'h66);
    chk_wr("t4_enq", 1'b1, 5'd4, 32'h400);
    tick;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 5'd4, 32'h400 + i, 1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STARVE_GUARD_EN
      if (i == 5) begin
        chk("t4_stall_trip", {31'd0, stall}, 32'd1);
        chk_wr("t4_trip_wr", 1'b1, 5'd6, 32'h66);
      end else begin
        chk("t4_stall", {31'd0, stall}, 32'd0);
        chk_wr("t4_p_wr", 1'b1, 5'd4, 32'h400 + i);
      end
`else
      chk("t4_stall", {31'd0, stall}, 32'd0);
      chk_wr("t4_p_wr", 1'b1, 5'd4, 32'h400 + i);
`endif
      tick;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STARVE_GUARD_EN
    chk_wr("t4_idle", 1'b0, 5'd0, 32'h0);
`else
    chk_wr("t4_idle_drain", 1'b1, 5'd6, 32'h66);
`endif
    tick;
    chk("t4_pending", {31'd0, s_pending}, 32'd0);
    chk("t4_rf6", rf[6], 32'h66);

    // x0 requests on both sides are ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 32'hDEAD0000 + i, 1'b1, 5'd0, 32'hBEEF0000 + i);
      chk_wr("t5_we3", 1'b0, 5'd0, 32'h0);
      chk("t5_ready", {31'd0, s_ready}, 32'd1);
      chk("t5_stall", {31'd0, stall}, 32'd0);
      tick;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t5_pending", {31'd0, s_pending}, 32'd0);
    chk_wr("t5_after", 1'b0, 5'd0, 32'h0);

    // Reset with two queued entries discards them
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
    tick;
    drive(1'b1, 5'd12, 32'hC1, 1'b1, 5'd14, 32'hE0);
    tick;
    drive(1'b1, 5'd12, 32'hC2, 1'b0, 5'd0, 32'h0);
    chk("t6_pending_pre", {31'd0, s_pending}, 32'd1);
    reset = 1'b1;
    drive(1'b1, 5'd12, 32'hC2, 1'b1, 5'd15, 32'hF0);
    chk_wr("t6_rst_we3", 1'b0, 5'd0, 32'h0);
    chk("t6_rst_a3", {27'd0, a3}, 32'd0);
    chk("t6_rst_ready", {31'd0, s_ready}, 32'd0);
    chk("t6_rst_pending", {31'd0, s_pending}, 32'd0);
    tick;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t6_pending_post", {31'd0, s_pending}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk_wr("t6_no_write", 1'b0, 5'd0, 32'h0);
      tick;
    end
    chk("t6_x13_never", {31'd0, wrote[13]}, 32'd0);
    chk("t6_x14_never", {31'd0, wrote[14]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
